// File: rtl/pc_predict_unit.sv
// Fetch PC register with a 2-bit-counter branch history table.
// Predicts JAL/branch targets in ID, resolves in EX, and redirects fetch with flushes on a mispredict.
module pc_predict_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BHT_IDX_W = 6,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [XLEN-1:0]  pc_f,
    input  logic             dec_valid,
    input  logic [1:0]       dec_branchjump,
    input  logic [XLEN-1:0]  dec_pc,
    input  logic [XLEN-1:0]  dec_pcimm,
    output logic             pred_taken_d,
    input  logic             ex_valid,
    input  logic [1:0]       ex_branchjump,
    input  logic             ex_flag,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_pc4,
    input  logic [XLEN-1:0]  ex_pcimm,
    input  logic [XLEN-1:0]  ex_pcjalr,
    output logic             flush_f,
    output logic             flush_d,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int BHT_N = 1 << BHT_IDX_W;

    localparam logic [1:0] BJ_BRANCH = 2'b01;
    localparam logic [1:0] BJ_JAL    = 2'b10;
    localparam logic [1:0] BJ_JALR   = 2'b11;

    logic [XLEN-1:0]             pc_q, pc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [BHT_N-1:0][1:0]       bht_q, bht_d;

    logic [BHT_IDX_W-1:0] dec_idx, ex_idx;
    logic [1:0]           dec_ctr, ex_ctr, ex_ctr_upd;
    logic                 pred_taken, ex_redirect, dec_redirect, bht_we;
    logic [XLEN-1:0]      ex_target;
    logic                 unused_pc_bits;

    // Only the index bits of the PCs address the table; the rest are deliberately ignored.
    assign unused_pc_bits = ^{dec_pc, ex_pc};

    assign dec_idx = dec_pc[BHT_IDX_W+1:2];
    assign ex_idx  = ex_pc[BHT_IDX_W+1:2];
    assign dec_ctr = bht_q[dec_idx];
    assign ex_ctr  = bht_q[ex_idx];

    always_comb begin
        pred_taken = !rst && dec_valid &&
                     ((dec_branchjump == BJ_BRANCH && dec_ctr[1]) || dec_branchjump == BJ_JAL);
        ex_redirect = !rst && ex_valid &&
                      (ex_branchjump == BJ_JALR ||
                       (ex_branchjump == BJ_BRANCH && ex_flag != ex_pred_taken));
        dec_redirect = pred_taken && !stall && !ex_redirect;
    end

    always_comb begin
        ex_target = ex_flag ? ex_pcimm : ex_pc4;
        if (ex_branchjump == BJ_JALR) begin
            ex_target = ex_pcjalr;
        end
    end

    // EX redirect beats everything, including stall: younger stalled work is flushed.
    always_comb begin
        if (ex_redirect) begin
            pc_d = ex_target;
        end else if (dec_redirect) begin
            pc_d = dec_pcimm;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ex_redirect && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Saturating 2-bit counter update; a same-cycle ID read still sees the old entry.
    always_comb begin
        bht_we     = ex_valid && ex_branchjump == BJ_BRANCH;
        ex_ctr_upd = ex_ctr;
        if (ex_flag && ex_ctr != 2'b11) begin
            ex_ctr_upd = ex_ctr + 2'd1;
        end else if (!ex_flag && ex_ctr != 2'b00) begin
            ex_ctr_upd = ex_ctr - 2'd1;
        end
        bht_d = bht_q;
        if (bht_we) begin
            bht_d[ex_idx] = ex_ctr_upd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            bht_q <= {BHT_N{2'b01}};
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            bht_q <= bht_d;
        end
    end

    assign pc_f           = pc_q;
    assign mispredict_cnt = cnt_q;
    assign pred_taken_d   = pred_taken;
    assign flush_f        = ex_redirect || dec_redirect;
    assign flush_d        = ex_redirect;

endmodule
